// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N requesters; one operation in flight,
// registered operands to the ALU and a registered, backpressured response.
module alu_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [N*32-1:0] req_a,
   input  logic [N*32-1:0] req_b,
   input  logic [N*5-1:0]  req_shamt,
   input  logic [N*4-1:0]  req_f,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [4:0]      alu_shamt,
   output logic [3:0]      alu_f,
   input  logic [31:0]     alu_y,
   input  logic            alu_zero,
   output logic            resp_valid,
   output logic [IW-1:0]   resp_id,
   output logic [31:0]     resp_y,
   output logic            resp_zero,
   input  logic            resp_ready
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] id_q, id_d;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   logic [4:0]    op_shamt_q, op_shamt_d;
   logic [3:0]    op_f_q, op_f_d;
   logic [31:0]   resp_y_q, resp_y_d;
   logic          resp_zero_q, resp_zero_d;

   logic [IW-1:0] win;
   logic          found;
   logic [IW:0]   idx;

   // Scan from ptr upward, wrapping modulo N; the first valid index wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr_q} + (IW+1)'(k);
         if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
         if (!found && req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end

   assign req_ready = (state_q == IDLE && found) ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_shamt_d  = op_shamt_q;
      op_f_d      = op_f_q;
      resp_y_d    = resp_y_q;
      resp_zero_d = resp_zero_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               op_a_d     = req_a[32*win +: 32];
               op_b_d     = req_b[32*win +: 32];
               op_shamt_d = req_shamt[5*win +: 5];
               op_f_d     = req_f[4*win +: 4];
               id_d       = win;
               ptr_d      = (win == IW'(N-1)) ? '0 : win + 1'b1;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            resp_y_d    = alu_y;
            resp_zero_d = alu_zero;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_shamt_q  <= '0;
         op_f_q      <= '0;
         resp_y_q    <= '0;
         resp_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_shamt_q  <= op_shamt_d;
         op_f_q      <= op_f_d;
         resp_y_q    <= resp_y_d;
         resp_zero_q <= resp_zero_d;
      end
   end

   // Outside EXEC the ALU sees a no-op code (1111 -> y=0) so it stays quiescent.
   assign alu_a      = (state_q == EXEC) ? op_a_q     : '0;
   assign alu_b      = (state_q == EXEC) ? op_b_q     : '0;
   assign alu_shamt  = (state_q == EXEC) ? op_shamt_q : '0;
   assign alu_f      = (state_q == EXEC) ? op_f_q     : 4'b1111;

   assign resp_valid = (state_q == RESP);
   assign resp_id    = id_q;
   assign resp_y     = resp_y_q;
   assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small behavioural ALU closes the loop, and every
// expected value below is a hand-computed constant.
module tb_alu_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  reqValid;
   logic [N-1:0]  reqReady;
   logic [N*32-1:0] reqA;
   logic [N*32-1:0] reqB;
   logic [N*5-1:0]  reqShamt;
   logic [N*4-1:0]  reqF;
   logic [31:0]   aluA;
   logic [31:0]   aluB;
   logic [4:0]    aluShamt;
   logic [3:0]    aluF;
   logic [31:0]   aluY;
   logic          aluZero;
   logic          respValid;
   logic [1:0]    respId;
   logic [31:0]   respY;
   logic          respZero;
   logic          respReady;

   int checkCount = 0;
   int passCount  = 0;

   alu_arbiter #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_a      (reqA),
      .req_b      (reqB),
      .req_shamt  (reqShamt),
      .req_f      (reqF),
      .alu_a      (aluA),
      .alu_b      (aluB),
      .alu_shamt  (aluShamt),
      .alu_f      (aluF),
      .alu_y      (aluY),
      .alu_zero   (aluZero),
      .resp_valid (respValid),
      .resp_id    (respId),
      .resp_y     (respY),
      .resp_zero  (respZero),
      .resp_ready (respReady)
   );

   // Free-running 100 MHz clock; the DUT acts on the rising edge.
   always #5 clk = ~clk;

   // Behavioural stand-in for the shared ALU that sits beside the arbiter in the parent.
   function automatic logic [31:0] tbAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [3:0] f);
      case (f)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0011: return b << sh;
         default: return 32'd0;
      endcase
   endfunction

   assign aluY    = tbAlu(aluA, aluB, aluShamt, aluF);
   assign aluZero = (aluY == 32'd0);

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      else passCount++;
   endtask

   // Loads one requester's operand lane without touching its valid bit.
   task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [3:0] f);
      reqA[id*32 +: 32]  = a;
      reqB[id*32 +: 32]  = b;
      reqShamt[id*5 +: 5] = sh;
      reqF[id*4 +: 4]    = f;
   endtask

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete isolated operation with resp_ready held high.
   task automatic runOp(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] f,
                        input logic [31:0] expY, input logic expZ, input string tag);
      applyStimulus(id, a, b, sh, f);
      reqValid[id] = 1'b1;
      #1;
      checkOutput({tag, "Ready"}, 32'(reqReady), 32'(4'b0001 << id));
      tick();
      reqValid[id] = 1'b0;
      checkOutput({tag, "AluA"}, aluA, a);
      checkOutput({tag, "AluB"}, aluB, b);
      checkOutput({tag, "AluShamt"}, 32'(aluShamt), 32'(sh));
      checkOutput({tag, "AluF"}, 32'(aluF), 32'(f));
      checkOutput({tag, "ExecNoResp"}, 32'(respValid), 32'd0);
      tick();
      checkOutput({tag, "RespValid"}, 32'(respValid), 32'd1);
      checkOutput({tag, "RespId"}, 32'(respId), 32'(id));
      checkOutput({tag, "RespY"}, respY, expY);
      checkOutput({tag, "RespZero"}, 32'(respZero), 32'(expZ));
      tick();
      checkOutput({tag, "BackIdle"}, 32'(respValid), 32'd0);
   endtask

   int gId[$];
   int gCyc[$];
   int rId[$];
   logic [31:0] rY[$];
   int rrOrder[6] = '{0, 1, 2, 3, 0, 1};
   logic [31:0] rrY[4] = '{32'd3, 32'd7, 32'h0F, 32'hFF};

   // Main directed sequence.
   initial begin
      reset     = 1'b0;
      reqValid  = '0;
      reqA      = '0;
      reqB      = '0;
      reqShamt  = '0;
      reqF      = '0;
      respReady = 1'b1;
      #1;
      checkOutput("rstRespValid", 32'(respValid), 32'd0);
      checkOutput("rstRespId", 32'(respId), 32'd0);
      checkOutput("rstRespY", respY, 32'd0);
      checkOutput("rstRespZero", 32'(respZero), 32'd0);
      checkOutput("rstAluF", 32'(aluF), 32'hF);
      checkOutput("rstReadyNone", 32'(reqReady), 32'd0);
      reqValid = 4'b0100;
      #1;
      checkOutput("rstReadyComb", 32'(reqReady), 32'b0100);
      reqValid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      runOp(0, 32'd5, 32'd7, 5'd0, 4'b0010, 32'd12, 1'b0, "single");
      runOp(2, 32'd9, 32'd9, 5'd0, 4'b0110, 32'd0, 1'b1, "zero");
      runOp(2, 32'd0, 32'd1, 5'd31, 4'b0011, 32'h8000_0000, 1'b0, "shift");
      runOp(3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 4'b0000, 32'hF000_F000, 1'b0, "wrap");

      // Round robin: all four requesters valid, starting from ptr=0.
      applyStimulus(0, 32'd1, 32'd2, 5'd0, 4'b0010);
      applyStimulus(1, 32'd10, 32'd3, 5'd0, 4'b0110);
      applyStimulus(2, 32'hFF, 32'h0F, 5'd0, 4'b0000);
      applyStimulus(3, 32'hF0, 32'h0F, 5'd0, 4'b0001);
      reqValid = 4'b1111;
      for (int c = 0; c < 60 && rId.size() < 6; c++) begin
         if (gId.size() >= 6) reqValid = '0;
         #1;
         for (int i = 0; i < N; i++) begin
            if (reqReady[i]) begin
               gId.push_back(i);
               gCyc.push_back(c);
            end
         end
         if (respValid) begin
            rId.push_back(int'(respId));
            rY.push_back(respY);
         end
         tick();
      end
      reqValid = '0;
      checkOutput("rrGrantCount", 32'(gId.size()), 32'd6);
      checkOutput("rrRespCount", 32'(rId.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < gId.size()) checkOutput($sformatf("rrGrant%0d", i), 32'(gId[i]), 32'(rrOrder[i]));
         if (i > 0 && i < gCyc.size())
            checkOutput($sformatf("rrGap%0d", i), 32'(gCyc[i] - gCyc[i-1]), 32'd3);
         if (i < rId.size()) begin
            checkOutput($sformatf("rrRespId%0d", i), 32'(rId[i]), 32'(rrOrder[i]));
            checkOutput($sformatf("rrRespY%0d", i), rY[i], rrY[rrOrder[i]]);
         end
      end

      // Backpressure: response held five cycles while requester 1 waits.
      respReady = 1'b0;
      applyStimulus(0, 32'd100, 32'd23, 5'd0, 4'b0010);
      reqValid = 4'b0001;
      #1;
      checkOutput("bpReady", 32'(reqReady), 32'b0001);
      tick();
      reqValid = '0;
      applyStimulus(1, 32'd50, 32'd8, 5'd0, 4'b0110);
      reqValid[1] = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("bpValid%0d", k), 32'(respValid), 32'd1);
         checkOutput($sformatf("bpY%0d", k), respY, 32'd123);
         checkOutput($sformatf("bpId%0d", k), 32'(respId), 32'd0);
         checkOutput($sformatf("bpNoReady%0d", k), 32'(reqReady), 32'd0);
         tick();
      end
      respReady = 1'b1;
      #1;
      checkOutput("bpStillValid", 32'(respValid), 32'd1);
      tick();
      checkOutput("bpNextAccept", 32'(reqReady), 32'b0010);
      tick();
      reqValid = '0;
      tick();
      checkOutput("bpNextId", 32'(respId), 32'd1);
      checkOutput("bpNextY", respY, 32'd42);
      tick();

      // Reset during EXEC discards the op and returns ptr to 0.
      applyStimulus(2, 32'd7, 32'd8, 5'd0, 4'b0010);
      reqValid = 4'b0100;
      #1;
      checkOutput("rstExecReady", 32'(reqReady), 32'b0100);
      tick();
      reqValid = '0;
      checkOutput("rstExecAluF", 32'(aluF), 32'b0010);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("rstMidAluF", 32'(aluF), 32'hF);
      checkOutput("rstMidAluA", aluA, 32'd0);
      checkOutput("rstMidValid", 32'(respValid), 32'd0);
      applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'b0010);
      applyStimulus(3, 32'd0, 32'd0, 5'd0, 4'b1101);
      reqValid = 4'b1010;
      #1;
      checkOutput("rstPtrDuring", 32'(reqReady), 32'b0010);
      tick();
      checkOutput("rstNoResp", 32'(respValid), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("rstFirstGrant", 32'(reqReady), 32'b0010);
      tick();
      reqValid[1] = 1'b0;
      tick();
      checkOutput("rstOpId", 32'(respId), 32'd1);
      checkOutput("rstOpY", respY, 32'd0);
      checkOutput("rstOpZero", 32'(respZero), 32'd1);
      checkOutput("rstOpNoReady", 32'(reqReady), 32'd0);
      tick();
      checkOutput("rstSecondGrant", 32'(reqReady), 32'b1000);
      tick();
      reqValid = '0;
      checkOutput("fwdUndefF", 32'(aluF), 32'hD);
      tick();
      checkOutput("fwdRespId", 32'(respId), 32'd3);
      checkOutput("fwdRespY", respY, 32'd0);
      tick();

      // Idle drive: quiescent ALU inputs with nothing requested.
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("idleAluF%0d", k), 32'(aluF), 32'hF);
         checkOutput($sformatf("idleAluA%0d", k), aluA, 32'd0);
         checkOutput($sformatf("idleAluB%0d", k), aluB, 32'd0);
         checkOutput($sformatf("idleReady%0d", k), 32'(reqReady), 32'd0);
         tick();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between `N` independent requesters, such as a multi-cycle datapath controller, an address-generation unit and a debug port. Each requester presents an ALU operation (`a`, `b`, `shamt`, `f`) with a valid/ready handshake. The block grants one requester at a time in round-robin order and drives the registered operands into the shared ALU. It captures `y`/`zero` and returns the result tagged with the requester index, with response backpressure. The block sits between the requesters and a single `alu` instance placed alongside it in the parent.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `IW`, default `$clog2(N)`: requester index width. Derived; do not override.

Ports:
- `clk` input 1: the only clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input N: bit i means requester i presents an operation.
- `req_ready` output N: bit i means requester i's operation is accepted this cycle. One-hot or zero.
- `req_a` input N*32: operand a; requester i occupies bits [32i+31:32i].
- `req_b` input N*32: operand b, same packing as `req_a`.
- `req_shamt` input N*5: shift amount, packed per requester.
- `req_f` input N*4: ALU function code, packed per requester.
- `alu_a`, `alu_b` output 32: to the shared ALU.
- `alu_shamt` output 5: to the shared ALU.
- `alu_f` output 4: to the shared ALU.
- `alu_y` input 32: from the shared ALU.
- `alu_zero` input 1: from the shared ALU.
- `resp_valid` output 1: a result is available.
- `resp_id` output IW: index of the requester that owns the result.
- `resp_y` output 32: registered ALU result.
- `resp_zero` output 1: registered zero flag.
- `resp_ready` input 1: consumer accepts the result.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- Round-robin pointer `ptr` (IW bits) gives the highest-priority index. Priority order is `ptr`, `ptr`+1, …, wrapping modulo N.
- **IDLE state:**
  - The winner is the first index i in priority order with `req_valid[i]=1`.
  - `req_ready` is combinational: `req_ready[i]=1` only for the winner, and only in IDLE.
  - On handshake (`req_valid[w] & req_ready[w]`): latch `a`, `b`, `shamt`, `f` and `w` into the op registers, set `ptr`←(w+1) mod N, and go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE and leave `ptr` unchanged.
- **EXEC state:**
  - `alu_*` are driven from the op registers.
  - At the end of the cycle, capture `alu_y`→`resp_y` and `alu_zero`→`resp_zero`, then go to RESP.
- **RESP state:**
  - `resp_valid`=1, and `resp_id` equals the latched w.
  - `resp_y`, `resp_zero` and `resp_id` hold stable until `resp_ready`=1.
  - On `resp_ready`=1, go to IDLE.
- **ALU drive outside EXEC:** `alu_a`/`alu_b`/`alu_shamt` are driven 0 and `alu_f`=4'b1111, which the ALU maps to y=0. The shared ALU is therefore quiescent and deterministic.
- **Operand pass-through:**
  - No arithmetic is done in this block.
  - Operands and results pass through at full 32-bit width, unmodified.
  - `f` is forwarded unchecked, including codes with no defined ALU function.
- **Requester obligations:** a requester must hold its operands stable while `req_valid`=1 and it has not yet been accepted. A requester may drop `req_valid` before acceptance without error.
- **Outstanding operations:** only one operation is in flight. No request is accepted in EXEC or RESP.

## Timing
- **Reset values (`reset`=0, asynchronous):**
  - state=IDLE, `ptr`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_y`=0, `resp_zero`=0.
  - Op registers are 0 and `alu_f` drives 4'b1111.
  - `req_ready` is combinational from state, so it is valid during reset and resolves to the IDLE winner.
- **Reset mid-operation:** an op in EXEC or RESP is discarded and no response is produced.
- **Latency:**
  - Accept edge T. EXEC occupies the cycle after T.
  - `resp_valid` rises after edge T+1, i.e. in the second cycle after acceptance.
- **Throughput:** with `resp_ready` held at 1, the next accept happens in the third cycle, giving 1 op per 3 cycles.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A requester that loses the grant keeps waiting. There is no starvation: any continuously-valid requester is served within N grants.
- **`ptr` wrap-around:** winner N-1 sets `ptr`=0.
- **`resp_ready` outside RESP:** ignored in IDLE and EXEC.
- **Response handshake:** completes in the same cycle `resp_valid` rises if `resp_ready` is already 1.

## Test plan
- **Single op:** requester 0 sends f=4'b0010, a=5, b=7. Required: `req_ready[0]`=1 in the same cycle; `resp_valid` two cycles later with `resp_id`=0, `resp_y`=12, `resp_zero`=0.
- **Zero flag and shift:**
  - Requester 2 sends f=4'b0110, a=b=9. Required: `resp_y`=0, `resp_zero`=1.
  - Then requester 2 sends f=4'b0011, b=1, shamt=31. Required: `resp_y`=32'h8000_0000.
- **Round-robin fairness:** all 4 requesters hold `req_valid` with distinct ops, and `resp_ready`=1. Required: grant order 0,1,2,3,0,1; accepts exactly 3 cycles apart; each `resp_id` matches its operation's result.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles during RESP. Required: `resp_valid`, `resp_y` and `resp_id` remain constant; `req_ready`=0 throughout; the next accept happens in the cycle after `resp_ready`=1 is sampled.
- **Reset mid-EXEC:** assert `reset`=0 mid-cycle during EXEC. Required: `resp_valid`=0 immediately; `ptr`=0; with requesters 1 and 3 valid after release, requester 1 is granted first.
- **Idle drive:** with no `req_valid`, check `alu_f`=4'b1111 and `alu_a`=`alu_b`=0 every cycle.
